// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out shifter with a one-word holding buffer.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [WIDTH-1:0] sh, hold, shifted;
  logic [CW-1:0]    cnt;
  logic             hold_v, accept, at_last;
  assign load_ready = ~hold_v & ~rst;
  assign accept     = load_valid & load_ready;
  assign at_last    = cnt == CW'(WIDTH - 1);
  assign shifted    = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
  assign frame      = state == SHIFT;
  assign serial_out = frame & (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
  assign last       = frame & at_last;
  assign busy       = frame | hold_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        sh    <= parallel_in;
        state <= SHIFT;
      end
    end else if (!at_last) begin
      sh  <= shifted;
      cnt <= cnt + 1'b1;
      if (accept) begin
        hold   <= parallel_in;
        hold_v <= 1'b1;
      end
    end else begin
      // word boundary: held word wins, then a same-edge accept, else go idle
      cnt <= '0;
      if (hold_v) begin
        sh     <= hold;
        hold_v <= 1'b0;
      end else if (accept) begin
        sh <= parallel_in;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of piso_serializer in MSB-first and LSB-first builds.
module tb_piso_serializer;
  logic       clk, rst;
  logic [3:0] pin_m, pin_l;
  logic       vld_m, vld_l;
  logic       rdy_m, so_m, frame_m, last_m, busy_m;
  logic       rdy_l, so_l, frame_l, last_l, busy_l;
  logic [3:0] sipo_m, sipo_l;
  int         errors = 0, checks = 0;
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .parallel_in(pin_m), .load_valid(vld_m), .load_ready(rdy_m),
    .serial_out(so_m), .frame(frame_m), .last(last_m), .busy(busy_m)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .parallel_in(pin_l), .load_valid(vld_l), .load_ready(rdy_l),
    .serial_out(so_l), .frame(frame_l), .last(last_l), .busy(busy_l)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    sipo_m <= {sipo_m[2:0], so_m};
    sipo_l <= {sipo_l[2:0], so_l};
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic [3:0]  words [3];
  logic [11:0] stream, rdy_exp;
  logic [7:0]  two;
  logic [3:0]  one;
  logic        acc;
  int          idx;
  initial begin
    rst = 1'b1; vld_m = 1'b0; vld_l = 1'b0; pin_m = '0; pin_l = '0;
    tick; tick;
    check("rst_so", so_m, 0);
    check("rst_frame", frame_m, 0);
    check("rst_last", last_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_ready", rdy_m, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", rdy_m, 1);
    tick;
    // single word, MSB first
    one = 4'b1011;
    pin_m = one; vld_m = 1'b1;
    tick;
    vld_m = 1'b0; pin_m = 4'bxxxx;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("single_so%0d", k), so_m, one[3-k]);
      check($sformatf("single_frame%0d", k), frame_m, 1);
      check($sformatf("single_last%0d", k), last_m, k == 3);
      tick;
    end
    check("single_so_idle", so_m, 0);
    check("single_frame_idle", frame_m, 0);
    check("single_busy_idle", busy_m, 0);
    check("single_sipo", sipo_m, 4'b1011);
    tick;
    // back-to-back with a producer that holds valid until each word is taken
    words = '{4'b1100, 4'b0110, 4'b1111};
    stream = 12'b1100_0110_1111;
    rdy_exp = 12'b1000_1000_1111;
    idx = 0; vld_m = 1'b1; pin_m = words[0];
    acc = vld_m & rdy_m;
    tick;
    for (int c = 0; c < 12; c++) begin
      if (acc) begin
        idx++;
        if (idx < 3) pin_m = words[idx];
        else vld_m = 1'b0;
      end
      check($sformatf("b2b_so%0d", c), so_m, stream[11-c]);
      check($sformatf("b2b_frame%0d", c), frame_m, 1);
      check($sformatf("b2b_last%0d", c), last_m, c % 4 == 3);
      check($sformatf("b2b_ready%0d", c), rdy_m, rdy_exp[11-c]);
      acc = vld_m & rdy_m;
      tick;
    end
    check("b2b_words_taken", idx, 3);
    check("b2b_frame_end", frame_m, 0);
    check("b2b_busy_end", busy_m, 0);
    check("b2b_sipo", sipo_m, 4'b1111);
    tick;
    // accept exactly on the last-bit edge with hold empty
    two = 8'b1000_0101;
    pin_m = 4'b1000; vld_m = 1'b1;
    tick;
    vld_m = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("edge_so%0d", c), so_m, two[7-c]);
      check($sformatf("edge_frame%0d", c), frame_m, 1);
      check($sformatf("edge_ready%0d", c), rdy_m, 1);
      vld_m = c == 3; pin_m = 4'b0101;
      tick;
    end
    check("edge_frame_end", frame_m, 0);
    check("edge_sipo", sipo_m, 4'b0101);
    // LSB first
    one = 4'b1011;
    pin_l = one; vld_l = 1'b1;
    tick;
    vld_l = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lsb_so%0d", k), so_l, one[k]);
      check($sformatf("lsb_last%0d", k), last_l, k == 3);
      tick;
    end
    check("lsb_frame_end", frame_l, 0);
    check("lsb_sipo", sipo_l, {one[0], one[1], one[2], one[3]});
    // reset mid-word with a word held
    pin_m = 4'b1111; vld_m = 1'b1;
    tick;
    pin_m = 4'b1010;
    tick;
    vld_m = 1'b0;
    check("midrst_busy_before", busy_m, 1);
    check("midrst_so_bit1", so_m, 1);
    tick;
    rst = 1'b1;
    #1;
    check("midrst_ready_in_rst", rdy_m, 0);
    tick;
    rst = 1'b0;
    #1;
    check("midrst_so", so_m, 0);
    check("midrst_frame", frame_m, 0);
    check("midrst_busy", busy_m, 0);
    check("midrst_ready_after", rdy_m, 1);
    for (int c = 0; c < 6; c++) begin
      tick;
      check($sformatf("midrst_quiet%0d", c), frame_m, 0);
    end
    // valid in the same cycle as reset is ignored
    rst = 1'b1; pin_m = 4'b1001; vld_m = 1'b1;
    #1;
    check("coll_ready_in_rst", rdy_m, 0);
    tick;
    rst = 1'b0; vld_m = 1'b0;
    #1;
    check("coll_frame", frame_m, 0);
    check("coll_busy", busy_m, 0);
    tick;
    check("coll_frame2", frame_m, 0);
    one = 4'b1001;
    pin_m = one; vld_m = 1'b1;
    tick;
    vld_m = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("coll_so%0d", k), so_m, one[3-k]);
      check($sformatf("coll_last%0d", k), last_m, k == 3);
      tick;
    end
    check("coll_sipo", sipo_m, 4'b1001);
    check("coll_frame_end", frame_m, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out stage that sits directly upstream of the 4-bit `sipo` deserializer and drives its `serial_in`. It accepts words through a valid/ready handshake and shifts them out one bit per `clk`. A one-word holding buffer lets consecutive words stream with no idle gap. `frame` and `last` mark word boundaries for the downstream side and the bench.

## Interface
Parameters:
- `WIDTH`, default 4: word width. Must be ≥ 2. The default matches the downstream `sipo`.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `parallel_in`  in  WIDTH  word to serialize; sampled on an accepted handshake.
- `load_valid`  in  1  producer has a word on `parallel_in`.
- `load_ready`  out  1  block can take a word this cycle.
- `serial_out`  out  1  serial bit stream; connects to `sipo.serial_in`.
- `frame`  out  1  high while `serial_out` carries a valid data bit.
- `last`  out  1  high during the final bit of each word.
- `busy`  out  1  high when in SHIFT or when the holding buffer is full.

## Operation
- State:
  - shift register `sh[WIDTH-1:0]`
  - bit counter `cnt`, width `$clog2(WIDTH)`
  - holding register `hold[WIDTH-1:0]` with flag `hold_v`
  - FSM with two states, IDLE and SHIFT
- Handshake:
  - `load_ready = ~hold_v & ~rst`.
  - A word is accepted on a rising edge where `load_valid & load_ready` is high.
  - `parallel_in` is don't-care when no word is accepted.
- IDLE:
  - Outputs: `serial_out=0`, `frame=0`, `last=0`, `cnt=0`.
  - On accept: `sh<=parallel_in`, go to SHIFT; `hold_v` stays 0.
- SHIFT:
  - `serial_out = MSB_FIRST ? sh[WIDTH-1] : sh[0]` (combinational from `sh`).
  - `frame=1`; `last = (cnt==WIDTH-1)`.
- Each SHIFT edge with `cnt<WIDTH-1`:
  - `sh` shifts toward the output end, zero-filling.
  - `cnt` increments.
  - An accept in this cycle writes `hold<=parallel_in` and sets `hold_v<=1`.
- SHIFT edge with `cnt==WIDTH-1`. `cnt<=0` in every case; priority is:
  1. If `hold_v`: `sh<=hold`, `hold_v<=0`, stay in SHIFT.
  2. Otherwise, on an accept: `sh<=parallel_in`, stay in SHIFT; `hold` is untouched.
  3. Otherwise: go to IDLE.
- `hold_v` and a same-edge accept cannot coincide, because `load_ready=0` whenever `hold_v=1`.
- `busy = (state==SHIFT) | hold_v`.
- Reset:
  - State: IDLE, `cnt=0`, `sh=0`, `hold=0`, `hold_v=0`.
  - Outputs: `serial_out=0`, `frame=0`, `last=0`, `busy=0`, and `load_ready=0` while `rst` is high.
  - Reset mid-word discards both the in-flight word and the held word with no partial completion.
  - A `load_valid` asserted in the same cycle as `rst` is not accepted.

## Timing
- Latency: accept at edge N puts the first bit on `serial_out` from edge N to edge N+1. Bit k is valid from edge N+k to N+k+1, for k=0..WIDTH-1.
- Downstream capture: the `sipo` captures each bit on the edge that ends its interval. The full word is present on `sipo.parallel_out` after edge N+WIDTH.
- Throughput: one bit per clock. Back-to-back words produce WIDTH·n contiguous `frame` cycles with no gap.
- `last` is high for exactly one cycle per word, coincident with the final bit.
- `load_ready`:
  - drops the cycle after `hold` fills;
  - rises the cycle after the last-bit edge that drains `hold`.
- The block has no combinational path from `load_valid` to `load_ready`. Only `rst` feeds `load_ready` combinationally.
- Exactly one of `frame=0` or a valid data bit holds on every cycle. `serial_out` is 0 whenever `frame=0`.

## Test plan
- **Single word:** WIDTH=4, MSB_FIRST=1; reset, then accept 4'b1011 at edge N.
  - `serial_out` = 1,0,1,1 over cycles N..N+3.
  - `frame` high for 4 cycles; `last` high only in cycle N+3.
  - Then `serial_out=0`, `frame=0`, `busy=0`.
  - `sipo.parallel_out` = 1011 after edge N+4.
- **Back-to-back:** hold `load_valid` high with 4'b1100, then 4'b0110, then 4'b1111.
  - 12 contiguous `frame` cycles carrying 1100_0110_1111.
  - `last` pulses at cycles 3, 7 and 11.
  - `load_ready` goes low while `hold` is full.
  - No word is lost or duplicated.
- **Last-bit-edge accept:** hold empty; present 4'b0101 exactly at the last-bit edge of 4'b1000.
  - Stream is 1000_0101 with no gap.
  - `hold_v` never sets.
- **LSB-first:** MSB_FIRST=0; accept 4'b1011.
  - `serial_out` = 1,1,0,1.
  - `sipo` sees the reversed order, which the checker must account for.
- **Reset mid-operation:** assert `rst` for 1 cycle after the 2nd bit of 4'b1111, with 4'b1010 held.
  - Next cycle: `serial_out=0`, `frame=0`, `busy=0`.
  - `load_ready` is 0 during `rst` and 1 the following cycle.
  - The held word is never emitted.
- **Reset/valid collision:** `load_valid=1` with 4'b1001 in the same cycle as `rst`.
  - No accept occurs and `frame` stays 0.
  - After release, re-presenting 4'b1001 serializes normally.
